// File: rtl/phase_run_controller_pkg.sv
// cpu_ctrl_pkg: shared states, status LED patterns and defaults for the phase/run controller
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RUN, STOP_PEND, STEP, HALTED} state_t;
  localparam logic [7:0] LED_RUN  = 8'b10011110;
  localparam logic [7:0] LED_IDLE = 8'b10110110;
  localparam logic [7:0] LED_HALT = 8'b11101100;
  localparam int DEF_NUM_PHASES = 5;
  function automatic logic is_exec(state_t s);
    return s inside {RUN, STOP_PEND, STEP};
  endfunction
endpackage

// File: rtl/phase_run_controller_ring.sv
// phase_ring_counter: registered one-hot phase enable with index and last-phase flag
module phase_ring_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  output logic [2:0]            o_idx,
  output logic [NUM_PHASES-1:0] o_en,
  output logic                  o_last
);
  logic [2:0] w_idx;
  assign o_last = o_en[NUM_PHASES-1];
  // restart at phase 0 after the last phase or when starting from idle
  assign w_idx = (|o_en && !o_last) ? o_idx + 3'd1 : 3'd0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_idx <= '0;
      o_en  <= '0;
    end else begin
      o_idx <= i_en ? w_idx : 3'd0;
      o_en  <= i_en ? NUM_PHASES'(1) << w_idx : '0;
    end
  end
endmodule

// File: rtl/phase_run_controller.sv
// phase_run_controller: run/stop/step/halt sequencing of one-hot instruction phases
module phase_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec_req,
  input  logic                  step_req,
  input  logic                  halt_in,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [2:0]            phase_idx,
  output logic                  running,
  output logic                  halted,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_count,
  output logic [7:0]            statusled,
  output logic [NUM_PHASES-1:0] clockled
);
  state_t     r_state, w_req, w_next;
  logic       r_halt, w_halt, w_last, w_run, w_hlt;
  logic [7:0] w_led;
  assign w_halt     = r_halt | (halt_in & |phase_en);
  assign instr_done = w_last;
  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_rev
    assign clockled[g] = phase_en[NUM_PHASES-1-g];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_halt      <= 1'b0;
      instr_count <= '0;
    end else begin
      r_state <= w_next;
      r_halt  <= w_halt;
      if (w_last) instr_count <= instr_count + CNT_W'(1);
    end
  end
  // requests act on the current state first; the boundary then decides run, idle or halt
  always_comb begin
    w_req  = r_state;
    w_req  = (r_state == IDLE) ? (exec_req ? RUN : step_req ? STEP : IDLE) :
             (r_state == RUN && exec_req) ? STOP_PEND :
             (r_state == STOP_PEND && exec_req) ? RUN : r_state;
    w_next = w_last ? (w_halt ? HALTED : (w_req == RUN) ? RUN : IDLE) : w_req;
  end
  always_comb begin
    w_run = is_exec(w_next);
    w_hlt = (w_next == HALTED);
    w_led = w_hlt ? LED_HALT : w_run ? LED_RUN : LED_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      running   <= 1'b0;
      halted    <= 1'b0;
      statusled <= LED_IDLE;
    end else begin
      running   <= w_run;
      halted    <= w_hlt;
      statusled <= w_led;
    end
  end
  phase_ring_counter #(.NUM_PHASES(NUM_PHASES)) u_ring (
    .i_clk (clock),
    .i_rst (reset),
    .i_en  (w_run),
    .o_idx (phase_idx),
    .o_en  (phase_en),
    .o_last(w_last)
  );
endmodule

// File: tb/tb_phase_run_controller.sv
// tb_phase_run_controller: vector-table and directed-sequence check of phase_run_controller
module tb_phase_run_controller;
  localparam logic [7:0] LR = 8'b10011110;
  localparam logic [7:0] LI = 8'b10110110;
  localparam logic [7:0] LH = 8'b11101100;
  logic clock = 1'b0, reset = 1'b1, exec_req = 1'b0, step_req = 1'b0, halt_in = 1'b0;
  logic [4:0] phase_en, clockled, en2, cl2;
  logic [2:0] phase_idx, idx2;
  logic running, halted, instr_done, run2, hlt2, done2;
  logic [15:0] instr_count;
  logic [3:0] cnt2;
  logic [7:0] statusled, led2;
  int total = 0, bad = 0;
  typedef struct {
    logic r, e, s, h;
    logic [4:0] en;
    logic [2:0] idx;
    logic [7:0] led;
    logic [15:0] cnt;
  } vec_t;
  vec_t v[$];
  always #5 clock = ~clock;
  phase_run_controller dut (
    .clock(clock), .reset(reset), .exec_req(exec_req), .step_req(step_req), .halt_in(halt_in),
    .phase_en(phase_en), .phase_idx(phase_idx), .running(running), .halted(halted),
    .instr_done(instr_done), .instr_count(instr_count), .statusled(statusled), .clockled(clockled)
  );
  phase_run_controller #(.NUM_PHASES(5), .CNT_W(4)) dut_w (
    .clock(clock), .reset(reset), .exec_req(exec_req), .step_req(step_req), .halt_in(halt_in),
    .phase_en(en2), .phase_idx(idx2), .running(run2), .halted(hlt2),
    .instr_done(done2), .instr_count(cnt2), .statusled(led2), .clockled(cl2)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic add(input logic r, e, s, h, input logic [4:0] en, input logic [2:0] idx,
                     input logic [7:0] led, input logic [15:0] cnt);
    v.push_back('{r, e, s, h, en, idx, led, cnt});
  endtask
  task automatic drive(input logic r, e, s, h);
    @(negedge clock);
    reset = r; exec_req = e; step_req = s; halt_in = h;
    @(posedge clock);
    #1;
  endtask
  function automatic logic [4:0] rev5(input logic [4:0] x);
    logic [4:0] y;
    for (int i = 0; i < 5; i++) y[i] = x[4-i];
    return y;
  endfunction
  initial begin
    int act, dn;
    // reset and plain run
    add(1,0,0,0,5'b00000,0,LI,0); add(0,0,0,0,5'b00000,0,LI,0);
    add(0,1,0,0,5'b00001,0,LR,0); add(0,0,0,0,5'b00010,1,LR,0); add(0,0,0,0,5'b00100,2,LR,0);
    add(0,0,0,0,5'b01000,3,LR,0); add(0,0,0,0,5'b10000,4,LR,0); add(0,0,0,0,5'b00001,0,LR,1);
    add(0,0,0,0,5'b00010,1,LR,1); add(0,0,0,0,5'b00100,2,LR,1);
    // stop requested in phase 2 finishes the instruction
    add(0,1,0,0,5'b01000,3,LR,1); add(0,0,0,0,5'b10000,4,LR,1); add(0,0,0,0,5'b00000,0,LI,2);
    add(0,0,0,0,5'b00000,0,LI,2);
    // single step, exec and step inside the step ignored
    add(0,0,1,0,5'b00001,0,LR,2); add(0,1,0,0,5'b00010,1,LR,2); add(0,0,0,0,5'b00100,2,LR,2);
    add(0,0,1,0,5'b01000,3,LR,2); add(0,0,0,0,5'b10000,4,LR,2); add(0,0,0,0,5'b00000,0,LI,3);
    add(0,0,0,0,5'b00000,0,LI,3);
    // stop then cancel, no gap across boundary
    add(0,1,0,0,5'b00001,0,LR,3); add(0,0,0,0,5'b00010,1,LR,3); add(0,0,0,0,5'b00100,2,LR,3);
    add(0,1,0,0,5'b01000,3,LR,3); add(0,1,0,0,5'b10000,4,LR,3); add(0,0,0,0,5'b00001,0,LR,4);
    add(0,0,0,0,5'b00010,1,LR,4); add(0,0,0,0,5'b00100,2,LR,4); add(0,0,0,0,5'b01000,3,LR,4);
    add(0,0,0,0,5'b10000,4,LR,4);
    // exec on last phase in RUN stops at this boundary
    add(0,1,0,0,5'b00000,0,LI,5);
    // exec on last phase in STOP_PEND keeps running
    add(0,1,0,0,5'b00001,0,LR,5); add(0,0,0,0,5'b00010,1,LR,5); add(0,0,0,0,5'b00100,2,LR,5);
    add(0,1,0,0,5'b01000,3,LR,5); add(0,0,0,0,5'b10000,4,LR,5); add(0,1,0,0,5'b00001,0,LR,6);
    add(0,0,0,0,5'b00010,1,LR,6);
    // halt pulsed in phase 1, then requests ignored
    add(0,0,0,1,5'b00100,2,LR,6); add(0,0,0,0,5'b01000,3,LR,6); add(0,0,0,0,5'b10000,4,LR,6);
    add(0,0,0,0,5'b00000,0,LH,7); add(0,1,0,0,5'b00000,0,LH,7); add(0,0,1,0,5'b00000,0,LH,7);
    add(0,1,1,0,5'b00000,0,LH,7);
    // halt beats a pending stop
    add(1,0,0,0,5'b00000,0,LI,0); add(0,1,0,0,5'b00001,0,LR,0); add(0,0,0,1,5'b00010,1,LR,0);
    add(0,1,0,0,5'b00100,2,LR,0); add(0,0,0,0,5'b01000,3,LR,0); add(0,0,0,0,5'b10000,4,LR,0);
    add(0,0,0,0,5'b00000,0,LH,1);
    // reset during phase 3
    add(1,0,0,0,5'b00000,0,LI,0); add(0,1,0,0,5'b00001,0,LR,0); add(0,0,0,0,5'b00010,1,LR,0);
    add(0,0,0,0,5'b00100,2,LR,0); add(0,0,0,0,5'b01000,3,LR,0); add(1,0,0,0,5'b00000,0,LI,0);
    add(0,0,0,0,5'b00000,0,LI,0);
    // exec wins over step from idle: runs continuously
    add(0,1,1,0,5'b00001,0,LR,0); add(0,0,0,0,5'b00010,1,LR,0); add(0,0,0,0,5'b00100,2,LR,0);
    add(0,0,0,0,5'b01000,3,LR,0); add(0,0,0,0,5'b10000,4,LR,0); add(0,0,0,0,5'b00001,0,LR,1);
    add(0,1,0,0,5'b00010,1,LR,1); add(0,0,0,0,5'b00100,2,LR,1); add(0,0,0,0,5'b01000,3,LR,1);
    add(0,0,0,0,5'b10000,4,LR,1); add(0,0,0,0,5'b00000,0,LI,2);
    foreach (v[k]) begin
      drive(v[k].r, v[k].e, v[k].s, v[k].h);
      chk($sformatf("v%0d phase_en", k), 32'(phase_en), 32'(v[k].en));
      chk($sformatf("v%0d phase_idx", k), 32'(phase_idx), 32'(v[k].idx));
      chk($sformatf("v%0d statusled", k), 32'(statusled), 32'(v[k].led));
      chk($sformatf("v%0d instr_count", k), 32'(instr_count), 32'(v[k].cnt));
      chk($sformatf("v%0d running", k), 32'(running), 32'(v[k].led == LR));
      chk($sformatf("v%0d halted", k), 32'(halted), 32'(v[k].led == LH));
      chk($sformatf("v%0d instr_done", k), 32'(instr_done), 32'(v[k].en[4]));
      chk($sformatf("v%0d clockled", k), 32'(clockled), 32'(rev5(v[k].en)));
    end
    // step: exactly five active cycles and one instr_done
    drive(1,0,0,0);
    drive(0,0,1,0);
    act = 0; dn = 0;
    for (int i = 0; i < 8; i++) begin
      act += int'(|phase_en);
      dn  += int'(instr_done);
      drive(0,0,0,0);
    end
    chk("step active cycles", 32'(act), 32'd5);
    chk("step instr_done", 32'(dn), 32'd1);
    chk("step count", 32'(instr_count), 32'd1);
    // counter wrap on the narrow-counter instance
    drive(1,0,0,0);
    drive(0,1,0,0);
    for (int i = 0; i < 75; i++) drive(0,0,0,0);
    chk("count 15", 32'(instr_count), 32'd15);
    chk("narrow count 15", 32'(cnt2), 32'd15);
    for (int i = 0; i < 5; i++) drive(0,0,0,0);
    chk("count 16", 32'(instr_count), 32'd16);
    chk("narrow count wrap", 32'(cnt2), 32'd0);
    chk("phase after wrap", 32'(phase_en), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
